sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO, successor to the fixed 8x8 sync FIFO.
//  - Configurable width and depth; occupancy count output.
//  - Programmable almost-full/almost-empty thresholds.
//  - Sticky overflow/underflow error flags; synchronous flush.
//  - Selectable standard (registered read) or first-word-fall-through output.
//  - Used as the generic buffering element between streaming stages in one clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_dpram.sv | 25 ++
 rtl/sync_fifo_param.sv | 136 +++++++++++++
 tb/tb_sync_fifo_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: address/count width helpers and output-mode encodings.
package fifo_pkg;

   typedef enum logic {
      FWFT_STD  = 1'b0,
      FWFT_FALL = 1'b1
   } fwft_mode_e;

   localparam int unsigned FIFO_DEF_DEPTH  = 8;
   localparam int unsigned FIFO_DEF_DATA_W = 8;

   function automatic int unsigned addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // One extra bit so a full FIFO (count == DEPTH) is representable.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_dpram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, sticky error
// flags, synchronous flush and selectable registered / fall-through output.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned DEPTH    = 8,
   parameter  int unsigned AF_LEVEL = 6,
   parameter  int unsigned AE_LEVEL = 2,
   parameter  int unsigned FWFT     = 0,
   localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned ADDR_W = addr_w(DEPTH);
   localparam fwft_mode_e  MODE   = (FWFT != 0) ? FWFT_FALL : FWFT_STD;

   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              af_q, af_d;
   logic              ae_q, ae_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_acc, rd_acc, mem_we;
   logic [DATA_W-1:0] mem_rdata;

   fifo_dpram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   always_comb begin
      wr_acc     = wr_en && !full_q;
      rd_acc     = rd_en && !empty_q;
      mem_we     = wr_acc && !clr;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ovf_d      = ovf_q || (wr_en && full_q);
      unf_d      = unf_q || (rd_en && empty_q);
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + CNT_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + CNT_W'(1);
         rd_data_d  = mem_rdata;
         rd_valid_d = 1'b1;
      end

      // Flush overrides any accepted transfer in the same cycle.
      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         ovf_d      = 1'b0;
         unf_d      = 1'b0;
         rd_data_d  = '0;
         rd_valid_d = 1'b0;
      end

      count_d = wr_ptr_d - rd_ptr_d;
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
      af_d    = (count_d >= CNT_W'(AF_LEVEL));
      ae_d    = (count_d <= CNT_W'(AE_LEVEL));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Fall-through mode presents the head word combinationally from storage.
   assign rd_data      = (MODE == FWFT_FALL) ? mem_rdata : rd_data_q;
   assign rd_valid     = (MODE == FWFT_FALL) ? !empty_q : rd_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance checked through
// an expected-data scoreboard, plus a fall-through instance.
module tb_sync_fifo_param;

   logic       clk, rst;

   logic       clr0, wr_en0, rd_en0;
   logic [7:0] wr_data0, rd_data0;
   logic       rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
   logic [3:0] count0;

   logic       clr1, wr_en1, rd_en1;
   logic [7:0] wr_data1, rd_data1;
   logic       rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
   logic [3:0] count1;

   int         checks, failures;
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];

   sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .clr(clr0), .wr_en(wr_en0), .wr_data(wr_data0),
      .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
      .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(unf0)
   );

   sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .clr(clr1), .wr_en(wr_en1), .wr_data(wr_data1),
      .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
      .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(unf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wr0(input logic [7:0] d);
      wr_en0   = 1'b1;
      wr_data0 = d;
      @(posedge clk);
      if (mq.size() < 8) mq.push_back(d);
      #1 wr_en0 = 1'b0;
   endtask

   task automatic rd0();
      bit acc;
      rd_en0 = 1'b1;
      @(posedge clk);
      acc = (mq.size() > 0);
      if (acc) exp_q.push_back(mq.pop_front());
      #1 rd_en0 = 1'b0;
      chk("rd_valid0_latency", rd_valid0, acc);
   endtask

   task automatic wrrd0(input logic [7:0] d);
      bit racc, wacc;
      wr_en0   = 1'b1;
      rd_en0   = 1'b1;
      wr_data0 = d;
      @(posedge clk);
      racc = (mq.size() > 0);
      wacc = (mq.size() < 8);
      if (racc) exp_q.push_back(mq.pop_front());
      if (wacc) mq.push_back(d);
      #1;
      wr_en0 = 1'b0;
      rd_en0 = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      clr0 = 0; wr_en0 = 0; rd_en0 = 0; wr_data0 = '0;
      clr1 = 0; wr_en1 = 0; rd_en1 = 0; wr_data1 = '0;

      // Scoreboard monitor: every rd_valid pulse must match the next expected word.
      fork
         forever begin
            logic [7:0] e;
            @(negedge clk);
            if (!rst && rd_valid0) begin
               if (exp_q.size() == 0) chk("rd_valid0_unexpected", rd_valid0, 1'b0);
               else begin
                  e = exp_q.pop_front();
                  chk("rd_data0", rd_data0, e);
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_empty", empty0, 1);
      chk("rst_almost_empty", ae0, 1);
      chk("rst_count", count0, 0);
      chk("rst_full", full0, 0);
      chk("rst_almost_full", af0, 0);
      chk("rst_rd_valid", rd_valid0, 0);
      chk("rst_overflow", ovf0, 0);
      chk("rst_underflow", unf0, 0);

      for (int i = 1; i <= 8; i++) begin
         wr0(8'(i));
         chk("fill_count", count0, i);
         chk("fill_almost_full", af0, (i >= 6));
         chk("fill_almost_empty", ae0, (i <= 2));
         chk("fill_full", full0, (i == 8));
         chk("fill_empty", empty0, 0);
      end
      wr0(8'hFF);
      chk("ovf_flag", ovf0, 1);
      chk("ovf_count", count0, 8);
      chk("ovf_full", full0, 1);

      for (int i = 1; i <= 8; i++) begin
         rd0();
         chk("drain_count", count0, 8 - i);
         chk("drain_empty", empty0, (i == 8));
      end
      chk("drain_no_underflow", unf0, 0);
      rd0();
      chk("unf_flag", unf0, 1);
      chk("ovf_sticky", ovf0, 1);

      clr0 = 1'b1;
      @(posedge clk);
      #1 clr0 = 1'b0;
      chk("clr_overflow", ovf0, 0);
      chk("clr_underflow", unf0, 0);
      chk("clr_empty", empty0, 1);

      for (int i = 0; i < 4; i++) wr0(8'h10 + 8'(i));
      chk("conc_start_count", count0, 4);
      for (int i = 0; i < 20; i++) begin
         wrrd0(8'h14 + 8'(i));
         chk("conc_count", count0, 4);
      end
      chk("conc_overflow", ovf0, 0);
      chk("conc_underflow", unf0, 0);
      for (int i = 0; i < 4; i++) rd0();
      chk("conc_drained", empty0, 1);

      for (int i = 0; i < 5; i++) wr0(8'h50 + 8'(i));
      chk("pre_rst_count", count0, 5);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_count", count0, 0);
      chk("async_rst_empty", empty0, 1);
      chk("async_rst_ae", ae0, 1);
      mq.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      wr0(8'h3C);
      rd0();
      @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      chk("fwft_idle_valid", rd_valid1, 0);
      wr_en1 = 1'b1; wr_data1 = 8'hA5;
      @(posedge clk);
      #1 wr_en1 = 1'b0;
      chk("fwft_rd_valid", rd_valid1, 1);
      chk("fwft_rd_data", rd_data1, 8'hA5);
      rd_en1 = 1'b1;
      @(posedge clk);
      #1 rd_en1 = 1'b0;
      chk("fwft_pop_empty", empty1, 1);
      chk("fwft_pop_valid", rd_valid1, 0);
      for (int i = 1; i <= 3; i++) begin
         wr_en1 = 1'b1; wr_data1 = 8'(8'h11 * i);
         @(posedge clk);
         #1 wr_en1 = 1'b0;
      end
      chk("fwft_count3", count1, 3);
      chk("fwft_head", rd_data1, 8'h11);
      clr1 = 1'b1; wr_en1 = 1'b1; wr_data1 = 8'h44;
      @(posedge clk);
      #1;
      clr1 = 1'b0; wr_en1 = 1'b0;
      chk("fwft_clr_count", count1, 0);
      chk("fwft_clr_empty", empty1, 1);
      chk("fwft_clr_valid", rd_valid1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
